// File: rtl/six_bit_dadda_mutliplier.sv
// 6x6 unsigned Dadda multiplier: combinational partial products, a 6->4->3->2 reduction
// tree built from explicit half/full adders, a ripple-carry final adder, and a registered product.
module six_bit_dadda_mutliplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  in1,
  input  logic [5:0]  in2,
  output logic [11:0] out
);

  function automatic logic [1:0] ha(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // pp[i][j] carries weight 2^(i+j)
  logic [5:0][5:0] pp;

  always_comb begin
    pp = '0;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        pp[i][j] = in1[i] & in2[j];
      end
    end
  end

  // Stage 1: heights reduced to 4 (columns 4..7 need work)
  logic s1_4, c1_4, s1_5a, c1_5a, s1_5b, c1_5b;
  logic s1_6a, c1_6a, s1_6b, c1_6b, s1_7, c1_7;

  assign {c1_4,  s1_4}  = ha(pp[4][0], pp[3][1]);
  assign {c1_5a, s1_5a} = fa(pp[5][0], pp[4][1], pp[3][2]);
  assign {c1_5b, s1_5b} = ha(pp[2][3], pp[1][4]);
  assign {c1_6a, s1_6a} = fa(pp[5][1], pp[4][2], pp[3][3]);
  assign {c1_6b, s1_6b} = ha(pp[2][4], pp[1][5]);
  assign {c1_7,  s1_7}  = fa(pp[5][2], pp[4][3], pp[3][4]);

  // Stage 2: heights reduced to 3 (columns 3..8)
  logic s2_3, c2_3, s2_4, c2_4, s2_5, c2_5;
  logic s2_6, c2_6, s2_7, c2_7, s2_8, c2_8;

  assign {c2_3, s2_3} = ha(pp[3][0], pp[2][1]);
  assign {c2_4, s2_4} = fa(s1_4, pp[2][2], pp[1][3]);
  assign {c2_5, s2_5} = fa(pp[0][5], s1_5a, s1_5b);
  assign {c2_6, s2_6} = fa(s1_6a, s1_6b, c1_5a);
  assign {c2_7, s2_7} = fa(pp[2][5], s1_7, c1_6a);
  assign {c2_8, s2_8} = fa(pp[5][3], pp[4][4], pp[3][5]);

  // Stage 3: heights reduced to 2 (columns 2..9)
  logic s3_2, c3_2, s3_3, c3_3, s3_4, c3_4, s3_5, c3_5;
  logic s3_6, c3_6, s3_7, c3_7, s3_8, c3_8, s3_9, c3_9;

  assign {c3_2, s3_2} = ha(pp[2][0], pp[1][1]);
  assign {c3_3, s3_3} = fa(s2_3, pp[1][2], pp[0][3]);
  assign {c3_4, s3_4} = fa(pp[0][4], s2_4, c2_3);
  assign {c3_5, s3_5} = fa(c1_4, s2_5, c2_4);
  assign {c3_6, s3_6} = fa(c1_5b, s2_6, c2_5);
  assign {c3_7, s3_7} = fa(c1_6b, s2_7, c2_6);
  assign {c3_8, s3_8} = fa(c1_7, s2_8, c2_7);
  assign {c3_9, s3_9} = fa(pp[5][4], pp[4][5], c2_8);

  logic [10:0] row_a;
  logic [10:0] row_b;

  assign row_a = {pp[5][5], s3_9, s3_8, s3_7, s3_6, s3_5, s3_4, s3_3, s3_2, pp[1][0], pp[0][0]};
  assign row_b = {c3_9, c3_8, c3_7, c3_6, c3_5, c3_4, c3_3, c3_2, pp[0][2], pp[0][1], 1'b0};

  // Ripple-carry final adder; the last carry becomes product bit 11
  logic [11:0] cy;
  logic [11:0] prod_d;
  logic [11:0] prod_q;

  always_comb begin
    cy     = '0;
    prod_d = '0;
    for (int k = 0; k < 11; k++) begin
      {cy[k+1], prod_d[k]} = fa(row_a[k], row_b[k], cy[k]);
    end
    prod_d[11] = cy[11];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign out = prod_q;

endmodule

// File: tb/tb_six_bit_dadda_mutliplier.sv
// Scoreboard bench for the 6x6 Dadda multiplier: stimulus pushes expected products,
// a monitor pops and compares one cycle after each sampling edge.
module tb_six_bit_dadda_mutliplier;

  logic        clk;
  logic        rst_n;
  logic [5:0]  in1;
  logic [5:0]  in2;
  logic [11:0] prod;

  int tests  = 0;
  int failed = 0;

  logic [11:0] sb_q[$];
  string       name_q[$];
  logic [11:0] last_exp;

  typedef struct {
    logic  r;
    int    a;
    int    b;
    int    e;
    string name;
  } vec_t;

  vec_t vecs[] = '{
    '{1'b0, 63, 51,    0, "rst_a"},
    '{1'b0, 63, 51,    0, "rst_b"},
    '{1'b1, 63, 51, 3213, "rel_63x51"},
    '{1'b1, 55, 51, 2805, "seq_55x51"},
    '{1'b1, 22, 33,  726, "seq_22x33"},
    '{1'b1, 33, 24,  792, "seq_33x24"},
    '{1'b1,  0,  0,    0, "c_0x0"},
    '{1'b1, 63,  0,    0, "c_63x0"},
    '{1'b1,  1, 63,   63, "c_1x63"},
    '{1'b1, 63, 63, 3969, "c_63x63"},
    '{1'b1, 45, 17,  765, "b2b_45x17"},
    '{1'b1, 17, 45,  765, "b2b_17x45"},
    '{1'b1, 62, 63, 3906, "b2b_62x63"},
    '{1'b1,  5, 60,  300, "b2b_5x60"},
    '{1'b1, 63,  1,   63, "b2b_63x1"},
    '{1'b1, 63, 51, 3213, "mid_63x51"},
    '{1'b0, 55, 51,    0, "mid_rst"},
    '{1'b1, 22, 33,  726, "mid_22x33"},
    '{1'b1, 33, 24,  792, "mid_33x24"}
  };

  six_bit_dadda_mutliplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in1   (in1),
    .in2   (in2),
    .out   (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are wiggled first, then settled, so only the value at the edge matters
  task automatic drive(input logic r, input int a, input int b, input int e, input string name);
    @(negedge clk);
    in1 = ~6'(a);
    in2 = ~6'(b);
    rst_n = r;
    if (!r && tests > 0) begin
      #1;
      check({name, "_hold"}, prod, last_exp);
    end
    #2;
    in1 = 6'(a);
    in2 = 6'(b);
    sb_q.push_back(12'(e));
    name_q.push_back(name);
    last_exp = 12'(e);
  endtask

  initial begin : monitor
    logic [11:0] exp;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        nm  = name_q.pop_front();
        check(nm, prod, exp);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n    = 1'b0;
    in1      = '0;
    in2      = '0;
    last_exp = '0;
    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].a, vecs[k].b, vecs[k].e, vecs[k].name);
    end
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        drive(1'b1, a, b, a * b, $sformatf("ex_%0dx%0d", a, b));
      end
    end
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (sb_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
